// File: rtl/sr_chk_pkg.sv
// Shared types and constants for the SR flip-flop response checker.
package sr_chk_pkg;

   typedef enum logic [1:0] {
      UNKNOWN = 2'b00,
      VALID   = 2'b01,
      INVALID = 2'b10
   } model_state_e;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_Q    = 2'b01;
   localparam logic [1:0] ERR_QBAR = 2'b10;
   localparam logic [1:0] ERR_BOTH = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && !(&cnt_q)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/sr_ff_checker.sv
// Observes S/R stimulus and Q/Q_bar of an SR flip-flop, compares against a
// reference model running one edge behind, and keeps pass/fail statistics.
module sr_ff_checker
   import sr_chk_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             S,
   input  logic             R,
   input  logic             Q,
   input  logic             Q_bar,
   output logic             exp_q,
   output logic             exp_valid,
   output logic             err,
   output logic [1:0]       err_code,
   output logic             err_sticky,
   output logic [CNT_W-1:0] check_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic [CNT_W-1:0] first_err_cycle
);

   model_state_e     state_q, state_d;
   logic             model_q_q, model_q_d;
   logic             exp_valid_q, exp_valid_d;
   logic             prev_valid_q, prev_valid_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0] first_err_cycle_q, first_err_cycle_d;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] cycle_next;

   logic do_cmp, q_fail, qbar_fail, fail;

   assign do_cmp    = EN && prev_valid_q;
   assign q_fail    = (state_q == VALID) && (Q != model_q_q);
   assign qbar_fail = (Q_bar == Q);
   assign fail      = do_cmp && (q_fail || qbar_fail);

   // Timestamp counts the current edge, so the first edge after reset is cycle 1.
   assign cycle_next = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);

   always_comb begin
      state_d           = state_q;
      model_q_d         = model_q_q;
      prev_valid_d      = 1'b1;
      err_d             = fail;
      err_code_d        = err_code_q;
      err_sticky_d      = err_sticky_q | fail;
      first_err_cycle_d = first_err_cycle_q;

      unique case ({S, R})
         2'b10: begin
            state_d   = VALID;
            model_q_d = 1'b1;
         end
         2'b01: begin
            state_d   = VALID;
            model_q_d = 1'b0;
         end
         2'b11:   state_d = INVALID;
         default: ;
      endcase
      exp_valid_d = (state_d == VALID);

      if (fail) begin
         if (q_fail && qbar_fail) begin
            err_code_d = ERR_BOTH;
         end else if (qbar_fail) begin
            err_code_d = ERR_QBAR;
         end else begin
            err_code_d = ERR_Q;
         end
         if (!err_sticky_q) begin
            first_err_cycle_d = cycle_next;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q           <= UNKNOWN;
         model_q_q         <= 1'b0;
         exp_valid_q       <= 1'b0;
         prev_valid_q      <= 1'b0;
         err_q             <= 1'b0;
         err_code_q        <= ERR_NONE;
         err_sticky_q      <= 1'b0;
         first_err_cycle_q <= '0;
      end else begin
         state_q           <= state_d;
         model_q_q         <= model_q_d;
         exp_valid_q       <= exp_valid_d;
         prev_valid_q      <= prev_valid_d;
         err_q             <= err_d;
         err_code_q        <= err_code_d;
         err_sticky_q      <= err_sticky_d;
         first_err_cycle_q <= first_err_cycle_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_check_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (do_cmp),
      .cnt (check_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (fail),
      .cnt (err_cnt)
   );

   sat_counter #(.W(CNT_W)) u_illegal_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (EN && S && R),
      .cnt (illegal_cnt)
   );

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (1'b1),
      .cnt (cycle_cnt)
   );

   assign exp_q           = model_q_q;
   assign exp_valid       = exp_valid_q;
   assign err             = err_q;
   assign err_code        = err_code_q;
   assign err_sticky      = err_sticky_q;
   assign first_err_cycle = first_err_cycle_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Directed self-checking bench for sr_ff_checker (16-bit and 3-bit counter builds).
module tb_sr_ff_checker;

   logic        CLK = 1'b0;
   logic        RST, EN, S, R, Q, Q_bar;
   logic        exp_q, exp_valid, err, err_sticky;
   logic [1:0]  err_code;
   logic [15:0] check_cnt, err_cnt, illegal_cnt, first_err_cycle;

   logic        s_rst, s_en, s_s, s_r, s_q, s_qb;
   logic        s_exp_q, s_exp_valid, s_err, s_err_sticky;
   logic [1:0]  s_err_code;
   logic [2:0]  s_check_cnt, s_err_cnt, s_illegal_cnt, s_first_err_cycle;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 CLK = ~CLK;

   sr_ff_checker #(.CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .S(S), .R(R), .Q(Q), .Q_bar(Q_bar),
      .exp_q(exp_q), .exp_valid(exp_valid), .err(err), .err_code(err_code),
      .err_sticky(err_sticky), .check_cnt(check_cnt), .err_cnt(err_cnt),
      .illegal_cnt(illegal_cnt), .first_err_cycle(first_err_cycle)
   );

   sr_ff_checker #(.CNT_W(3)) u_sat (
      .CLK(CLK), .RST(s_rst), .EN(s_en), .S(s_s), .R(s_r), .Q(s_q), .Q_bar(s_qb),
      .exp_q(s_exp_q), .exp_valid(s_exp_valid), .err(s_err), .err_code(s_err_code),
      .err_sticky(s_err_sticky), .check_cnt(s_check_cnt), .err_cnt(s_err_cnt),
      .illegal_cnt(s_illegal_cnt), .first_err_cycle(s_first_err_cycle)
   );

   // Drive inputs, take one rising edge, then sample 1 time unit later.
   task automatic step(input logic en, input logic s, input logic r, input logic q,
                       input logic qb);
      EN = en; S = s; R = r; Q = q; Q_bar = qb;
      @(posedge CLK);
      #1;
   endtask

   // Reset with EN=1 and S=R=1 held so RST priority is exercised.
   task automatic do_reset();
      RST = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({exp_q, exp_valid, err, err_code, err_sticky} !== 6'b0)
         $display("FAIL reset_flags got %b want 000000",
                  {exp_q, exp_valid, err, err_code, err_sticky});
      else pass_cnt++;
      total_cnt++;
      if ({check_cnt, err_cnt, illegal_cnt, first_err_cycle} !== 64'd0)
         $display("FAIL reset_counters got %h want 0",
                  {check_cnt, err_cnt, illegal_cnt, first_err_cycle});
      else pass_cnt++;
   endtask

   task automatic test_golden();
      logic [1:0] sr_seq  [6] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10};
      logic [1:0] exp_seq [6] = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b11};
      logic ff = 1'b0;
      logic [1:0] sr;
      logic [1:0] e;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         sr = sr_seq[i];
         e  = exp_seq[i];
         step(1'b1, sr[1], sr[0], ff, ~ff);
         if (sr == 2'b10) ff = 1'b1;
         else if (sr != 2'b00) ff = 1'b0;
         total_cnt++;
         if ({exp_valid, exp_q, err} !== {e, 1'b0})
            $display("FAIL golden_edge%0d valid/q/err got %b want %b", i + 1,
                     {exp_valid, exp_q, err}, {e, 1'b0});
         else pass_cnt++;
      end
      total_cnt++;
      if (illegal_cnt !== 16'd1) $display("FAIL golden_illegal got %0d want 1", illegal_cnt);
      else pass_cnt++;
      total_cnt++;
      if (check_cnt !== 16'd5) $display("FAIL golden_checks got %0d want 5", check_cnt);
      else pass_cnt++;
      total_cnt++;
      if ({err_cnt, err_sticky} !== 17'd0)
         $display("FAIL golden_no_err got cnt=%0d sticky=%b want 0/0", err_cnt, err_sticky);
      else pass_cnt++;
   endtask

   // Stuck-at-0 Q, then a mid-run reset after two errors.
   task automatic test_stuck_and_midrun_reset();
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (err !== 1'b0) $display("FAIL stuck_edge2_err got %b want 0", err);
      else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if ({err, err_code, err_sticky} !== 4'b1011)
         $display("FAIL stuck_edge3 err/code/sticky got %b want 1011",
                  {err, err_code, err_sticky});
      else pass_cnt++;
      total_cnt++;
      if (first_err_cycle !== 16'd3) $display("FAIL stuck_first_cycle got %0d want 3",
                                              first_err_cycle);
      else pass_cnt++;
      total_cnt++;
      if ({err_cnt, check_cnt} !== {16'd1, 16'd2})
         $display("FAIL stuck_counts got err=%0d chk=%0d want 1/2", err_cnt, check_cnt);
      else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if ({err, err_cnt, first_err_cycle} !== {1'b1, 16'd2, 16'd3})
         $display("FAIL stuck_edge4 err=%b cnt=%0d first=%0d want 1/2/3",
                  err, err_cnt, first_err_cycle);
      else pass_cnt++;
      RST = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      RST = 1'b0;
      total_cnt++;
      if ({exp_q, exp_valid, err, err_code, err_sticky, check_cnt, err_cnt, illegal_cnt,
           first_err_cycle} !== 70'd0)
         $display("FAIL midrun_reset outputs not cleared err=%b code=%b chk=%0d ecnt=%0d",
                  err, err_code, check_cnt, err_cnt);
      else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({err, check_cnt} !== {1'b0, 16'd0})
         $display("FAIL post_reset_edge1 err=%b chk=%0d want 0/0", err, check_cnt);
      else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if ({err, err_code, check_cnt, first_err_cycle} !== {3'b110, 16'd1, 16'd2})
         $display("FAIL post_reset_edge2 err=%b code=%b chk=%0d first=%0d want 1/10/1/2",
                  err, err_code, check_cnt, first_err_cycle);
      else pass_cnt++;
   endtask

   task automatic test_qbar_tied();
      logic [1:0] sr_seq   [3] = '{2'b00, 2'b01, 2'b00};
      logic [1:0] code_seq [3] = '{2'b10, 2'b10, 2'b11};
      logic [1:0] sr;
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         sr = sr_seq[i];
         step(1'b1, sr[1], sr[0], 1'b1, 1'b1);
         total_cnt++;
         if ({err, err_code} !== {1'b1, code_seq[i]})
            $display("FAIL qbar_tied_cmp%0d err/code got %b want %b", i + 1,
                     {err, err_code}, {1'b1, code_seq[i]});
         else pass_cnt++;
      end
      total_cnt++;
      if (err_cnt !== 16'd3) $display("FAIL qbar_tied_errcnt got %0d want 3", err_cnt);
      else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if ({err, err_code} !== 3'b011)
         $display("FAIL qbar_code_hold got %b want 011", {err, err_code});
      else pass_cnt++;
   endtask

   task automatic test_en_gap();
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         total_cnt++;
         if ({err, check_cnt, err_cnt} !== {1'b0, 16'd1, 16'd0})
            $display("FAIL en_gap%0d err=%b chk=%0d ecnt=%0d want 0/1/0", i,
                     err, check_cnt, err_cnt);
         else pass_cnt++;
      end
      total_cnt++;
      if ({exp_valid, exp_q} !== 2'b11)
         $display("FAIL en_gap_model got %b want 11", {exp_valid, exp_q});
      else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      total_cnt++;
      if ({err, check_cnt, err_sticky} !== {1'b0, 16'd2, 1'b0})
         $display("FAIL en_resume err=%b chk=%0d sticky=%b want 0/2/0",
                  err, check_cnt, err_sticky);
      else pass_cnt++;
   endtask

   task automatic test_saturate();
      s_en = 1'b1; s_s = 1'b1; s_r = 1'b0; s_q = 1'b0; s_qb = 1'b0;
      s_rst = 1'b1;
      @(posedge CLK); #1;
      s_rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK); #1;
         if (i == 8 || i == 9) begin
            total_cnt++;
            if ({s_err_cnt, s_check_cnt} !== {3'd7, 3'd7})
               $display("FAIL sat_edge%0d err=%0d chk=%0d want 7/7", i, s_err_cnt,
                        s_check_cnt);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if ({s_err, s_err_cnt, s_check_cnt, s_first_err_cycle} !== {1'b1, 3'd7, 3'd7, 3'd2})
         $display("FAIL sat_final err=%b ecnt=%0d chk=%0d first=%0d want 1/7/7/2",
                  s_err, s_err_cnt, s_check_cnt, s_first_err_cycle);
      else pass_cnt++;
   endtask

   initial begin
      RST = 1'b1; EN = 1'b0; S = 1'b0; R = 1'b0; Q = 1'b0; Q_bar = 1'b1;
      s_rst = 1'b1; s_en = 1'b0; s_s = 1'b0; s_r = 1'b0; s_q = 1'b0; s_qb = 1'b1;
      test_reset();
      test_golden();
      test_stuck_and_midrun_reset();
      test_qbar_tied();
      test_en_gap();
      test_saturate();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
